// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB requester types and pprot bit constants
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
  localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: command port to SETUP/ACCESS phases with wait timeout
module apb_requester
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      cmd_write,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [BYTES_PER_WORD-1:0] cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [BYTES_PER_WORD-1:0] pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  // A zero timeout still needs a legal counter width; the counter is simply never compared then.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Timeout fires while the counter shows the last permitted ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_state_e    state;
  apb_state_e    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          done;
  logic          timeout_hit;

  // State register
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Completion and timeout qualifiers for the current ACCESS cycle
  always_comb begin
    done        = (state == ACCESS) && pready;
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) timeout_hit = (state == ACCESS) && !pready && (wait_cnt == TLIM);
    accept      = cmd_valid && cmd_ready;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (pready)           state_nxt = accept ? SETUP : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase outputs and command handshake decoded from the state
  always_comb begin
    psel      = (state != IDLE);
    penable   = (state == ACCESS);
    cmd_ready = !preset && ((state == IDLE) || ((state == ACCESS) && pready));
  end

  // APB request fields, wait counter and response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        paddr    <= cmd_addr;
        pprot    <= cmd_prot;
        pwrite   <= cmd_write;
        pwdata   <= cmd_wdata;
        pstrb    <= cmd_strb;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      // pwrite here still belongs to the finishing transfer even when a new command is latched this edge
      if (done) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - randomized scoreboard bench for apb_requester
module tb_apb_requester;
  import apb_pkg::*;

  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [9:0]  paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;

  always #5 pclk = ~pclk;

  apb_requester #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {logic [31:0] rdata; logic err; logic to; int lat; int acc;} exp_t;
  typedef struct {int waits; logic [2:0] prot; logic [9:0] addr; logic wr;} comp_t;

  exp_t        exp_q[$];
  comp_t       comp_q[$];
  logic [31:0] ref_mem[256];
  logic [31:0] slv_mem[256];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  always @(posedge pclk) cyc <= cyc + 1;

  // Completer: region 2 never answers, region 3 answers with pslverr, others are plain memory
  bit          in_acc = 0;
  int          wcnt;
  comp_t       cur;
  logic        prev_psel = 0, prev_pen = 0, prev_rdy = 0, prev_wr = 0;
  logic [9:0]  prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_strb;
  logic [2:0]  prev_prot;

  always @(negedge pclk) begin
    if (preset) begin
      in_acc = 0; pready = 0; pslverr = 0; prdata = 0;
      prev_psel = 0; prev_pen = 0; prev_rdy = 0;
    end else begin
      if (penable) check("penable_without_psel", {31'b0, psel}, 32'd1);
      if (psel && penable && !(prev_psel && prev_pen && !prev_rdy))
        check("setup_before_access", {30'b0, prev_psel, prev_pen}, 32'd2);
      if (psel && !penable && prev_psel && !prev_pen)
        check("setup_one_cycle", {31'b0, penable}, 32'd1);
      if (prev_psel && prev_pen && !prev_rdy && psel) begin
        check("wait_penable", {31'b0, penable}, 32'd1);
        check("wait_paddr", {22'b0, paddr}, {22'b0, prev_addr});
        check("wait_pwdata", pwdata, prev_wdata);
        check("wait_ctrl", {24'b0, pwrite, pstrb, pprot}, {24'b0, prev_wr, prev_strb, prev_prot});
      end
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1; wcnt = 0;
          if (comp_q.size() == 0) begin
            cur.waits = 0;
            check("access_without_command", 32'd1, 32'd0);
          end else begin
            cur = comp_q.pop_front();
            check("bus_addr", {22'b0, paddr}, {22'b0, cur.addr});
            check("bus_write_prot", {28'b0, pwrite, pprot}, {28'b0, cur.wr, cur.prot});
          end
        end
        if (paddr[9:8] != 2'b10 && wcnt == cur.waits) begin
          pready  = 1;
          pslverr = (paddr[9:8] == 2'b11);
          prdata  = pslverr ? ({22'b0, paddr} ^ 32'hBAD0_0000) : slv_mem[paddr[9:2]];
          if (pwrite && !pslverr) slv_mem[paddr[9:2]] = merge(slv_mem[paddr[9:2]], pwdata, pstrb);
        end else begin
          pready = 0; pslverr = 1'($urandom); prdata = $urandom;
        end
        wcnt++;
      end else begin
        in_acc = 0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      prev_psel = psel; prev_pen = penable; prev_rdy = pready; prev_addr = paddr;
      prev_wdata = pwdata; prev_strb = pstrb; prev_prot = pprot; prev_wr = pwrite;
    end
  end

  // Response monitor
  exp_t e_mon;
  always @(negedge pclk) begin
    if (!preset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e_mon.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e_mon.err});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e_mon.to});
        check("rsp_latency", cyc - e_mon.acc, e_mon.lat);
      end
    end
  end

  task automatic send(input logic [9:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int waits, output int acc);
    exp_t  e;
    comp_t c;
    int    n = 0;
    cmd_valid = 1; cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = 3'($urandom);
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk); #1; n++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      check("cmd_accept_bound", 32'd0, 32'd1);
      cmd_valid = 0;
      return;
    end
    e.acc = cyc; e.to = 0; e.err = 0; e.rdata = 0; e.lat = 3 + waits;
    if (a[9:8] == 2'b10) begin
      e.err = 1; e.to = 1; e.lat = 2 + TO;
    end else if (a[9:8] == 2'b11) begin
      e.err = 1;
      if (!w) e.rdata = {22'b0, a} ^ 32'hBAD0_0000;
    end else if (w) begin
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
    end else begin
      e.rdata = ref_mem[a[9:2]];
    end
    exp_q.push_back(e);
    c.waits = waits; c.prot = cmd_prot; c.addr = a; c.wr = w;
    comp_q.push_back(c);
    @(negedge pclk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) @(negedge pclk);
  endtask

  int acc, last_acc, r, w8;
  logic [9:0] ra;

  initial begin
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 0; slv_mem[i] = 0; end
    preset = 1; cmd_valid = 1; cmd_addr = 10'h3FF; cmd_write = 1;
    cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_prot = 3'h7;
    repeat (2) begin
      @(negedge pclk);
      #1;
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_psel_penable", {30'b0, psel, penable}, 32'd0);
      check("rst_paddr", {22'b0, paddr}, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_ctrl", {24'b0, pwrite, pstrb, pprot}, 32'd0);
      check("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
    end
    preset = 0; cmd_valid = 0;
    @(negedge pclk);

    send(10'h04C, 1, 32'hDEAD_BEEF, 4'hF, 0, acc); idle(5);
    send(10'h100, 1, 32'h1234_5678, 4'hF, 1, acc); idle(2);
    send(10'h100, 0, 32'h0, 4'h0, 3, acc); idle(3);
    send(10'h04C, 0, 32'h0, 4'h0, 0, acc); idle(3);
    send(10'h3A0, 1, 32'hCAFE_F00D, 4'h3, 0, acc); idle(2);
    send(10'h050, 1, 32'hA5A5_A5A5, 4'h5, 2, acc); idle(1);
    send(10'h050, 0, 32'h0, 4'h0, 0, acc); idle(4);

    send(10'h010, 1, 32'h1111_1111, 4'hF, 0, last_acc);
    for (int i = 0; i < 3; i++) begin
      send(10'h014 + 10'(i * 4), (i != 1), 32'h2222_0000 + i, 4'hF, 0, acc);
      check("b2b_spacing", acc - last_acc, 32'd2);
      last_acc = acc;
    end
    idle(6);

    send(10'h200, 0, 32'h0, 4'h0, 0, acc); idle(14);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 99);
      ra = 10'($urandom);
      if (r < 5)       ra[9:8] = 2'b10;
      else if (r < 15) ra[9:8] = 2'b11;
      else             ra[9:8] = 2'($urandom_range(0, 1));
      w8 = $urandom_range(0, 4);
      send(ra, 1'($urandom), $urandom, 4'($urandom), w8, acc);
      r = $urandom_range(0, 2);
      if (r != 0) idle(r);
    end
    idle(16);

    send(10'h2F0, 1, 32'h0BAD_0BAD, 4'hF, 0, acc);
    cmd_valid = 0;
    repeat (4) @(negedge pclk);
    #2 preset = 1;
    @(negedge pclk);
    check("midrst_psel_penable", {30'b0, psel, penable}, 32'd0);
    exp_q.delete();
    comp_q.delete();
    @(negedge pclk);
    preset = 0;
    idle(15);
    send(10'h0C0, 0, 32'h0, 4'h0, 1, acc);
    idle(1);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge pclk);
    check("drain_exp_q", exp_q.size(), 32'd0);
    check("drain_comp_q", comp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
